// File: rtl/pc_fetch.sv
// pc_fetch: program-counter sequencer with an IDLE / RUN / HALT control FSM.
//
// Ports:
//   clk         single clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   start       begin execution from address 0 (from IDLE or HALT)
//   stall       hold the PC this cycle
//   branch_en   taken branch / jump this cycle, target from the branch table
//   jump_idx    branch-target table index
//   lut_addr    index driven to the branch-target table (combinational)
//   lut_target  absolute target returned by the table (same cycle)
//   halt_req    current instruction is the program-end instruction
//   prog_ctr    current instruction address
//   running     high in RUN
//   done        high in HALT
//
// Optional feature (macro PC_FETCH_RET_STACK_EN):
//   call_en     push prog_ctr+1 and jump to lut_target
//   ret_en      pop the return address into prog_ctr
//   stack_err   sticky overflow/underflow flag, cleared only by reset
//   A 4-entry return-address stack backs call/ret.

module pc_fetch #(
    parameter int unsigned D = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stall,
    input  logic         branch_en,
    input  logic [3:0]   jump_idx,
    output logic [3:0]   lut_addr,
    input  logic [D-1:0] lut_target,
    input  logic         halt_req,
`ifdef PC_FETCH_RET_STACK_EN
    input  logic         call_en,
    input  logic         ret_en,
    output logic         stack_err,
`endif
    output logic [D-1:0] prog_ctr,
    output logic         running,
    output logic         done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } state_e;

    state_e       r_state;
    state_e       w_state_d;
    logic [D-1:0] r_pc;
    logic [D-1:0] w_pc_d;
    logic [D-1:0] w_pc_inc;

    // Natural wrap from 2^D-1 to 0, no flag.
    assign w_pc_inc = r_pc + D'(1);

    // The table is read in the same cycle the index is presented.
    assign lut_addr = jump_idx;

`ifdef PC_FETCH_RET_STACK_EN
    logic [D-1:0] r_stack [4];
    logic [2:0]   r_sp;      // number of valid entries, 0..4
    logic         r_err;
    logic         w_push;
    logic         w_pop;
    logic         w_err_set;
    logic [1:0]   w_sp_top;

    assign w_sp_top  = r_sp[1:0] - 2'd1;
    assign stack_err = r_err;
`endif

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
`ifdef PC_FETCH_RET_STACK_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
`endif
        unique case (r_state)
            StIdle, StHalt: begin
                if (start) begin
                    w_state_d = StRun;
                    w_pc_d    = '0;
                end
            end
            StRun: begin
                if (halt_req) begin
                    w_state_d = StHalt;
                end else if (stall) begin
                    w_pc_d = r_pc;
`ifdef PC_FETCH_RET_STACK_EN
                end else if (ret_en) begin
                    if (r_sp != 3'd0) begin
                        w_pc_d = r_stack[w_sp_top];
                        w_pop  = 1'b1;
                    end else begin
                        // Underflow: fall through to sequential flow.
                        w_pc_d    = w_pc_inc;
                        w_err_set = 1'b1;
                    end
                end else if (call_en) begin
                    // Overflow still jumps; only the push is dropped.
                    w_pc_d = lut_target;
                    if (r_sp != 3'd4) begin
                        w_push = 1'b1;
                    end else begin
                        w_err_set = 1'b1;
                    end
`endif
                end else if (branch_en) begin
                    w_pc_d = lut_target;
                end else begin
                    w_pc_d = w_pc_inc;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
        end
    end

`ifdef PC_FETCH_RET_STACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_stack[i] <= '0;
            end
            r_sp  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_stack[r_sp[1:0]] <= w_pc_inc;
                r_sp               <= r_sp + 3'd1;
            end else if (w_pop) begin
                r_sp <= r_sp - 3'd1;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end
`endif

    assign prog_ctr = r_pc;
    // Decoded purely from the state register.
    assign running  = (r_state == StRun);
    assign done     = (r_state == StHalt);

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter D, default 10: program-counter width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: begin program execution from address 0.
REQ-005 SHALL have port stall, input, 1 bit: hold the PC this cycle.
REQ-006 SHALL have port branch_en, input, 1 bit: taken branch or jump this cycle.
REQ-007 SHALL have port jump_idx, input, 4 bits: branch-target table index.
REQ-008 SHALL have port lut_addr, output, 4 bits: index driven to the branch-target table.
REQ-009 SHALL have port lut_target, input, D bits: absolute target returned by the table.
REQ-010 SHALL have port halt_req, input, 1 bit: the current instruction is the program-end instruction.
REQ-011 SHALL have port prog_ctr, output, D bits: current instruction address.
REQ-012 SHALL have port running, output, 1 bit: high in RUN.
REQ-013 SHALL have port done, output, 1 bit: high in HALT.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, RUN and HALT.
REQ-015 SHALL make the IDLE-to-RUN transition on start=1, holding prog_ctr=0.
REQ-016 SHALL, in RUN, select the next PC by priority halt_req > stall > branch_en > sequential.
REQ-017 SHALL, in RUN on halt_req=1, go to HALT and leave prog_ctr unchanged.
REQ-018 SHALL, in RUN on stall=1 without halt_req, leave prog_ctr unchanged and ignore branch_en.
REQ-019 SHALL, in RUN on branch_en=1, load prog_ctr with lut_target on the next edge.
REQ-020 SHALL otherwise, in RUN, load prog_ctr with (prog_ctr+1) mod 2^D, wrapping 2^D-1 to 0 with no flag.
REQ-021 SHALL drive lut_addr combinationally equal to jump_idx in every state, so lut_target is consumed in the same cycle (zero latency).
REQ-022 SHALL, in HALT, ignore all inputs except start, which loads prog_ctr=0 and enters RUN.
REQ-023 SHALL, in IDLE, ignore stall, branch_en and halt_req.
REQ-024 SHALL decode running and done from the state register with no combinational input paths.

Reset
REQ-025 SHALL, on rst_n=0 and without waiting for clk, force state=IDLE, prog_ctr=0, running=0 and done=0, including mid-RUN.
REQ-026 SHALL also clear the return stack and stack_err under the same reset when RET_STACK_EN is defined.
REQ-027 SHALL resume in IDLE after rst_n deasserts, requiring start before execution continues.

Configuration
REQ-028 SHALL, when macro PC_FETCH_RET_STACK_EN is defined, add the 1-bit inputs call_en and ret_en, the 1-bit sticky output stack_err, and a 4-entry return-address stack.
REQ-029 SHALL, with the macro, use RUN priority halt_req > stall > ret_en > call_en > branch_en > sequential.
REQ-030 SHALL, on call_en, push prog_ctr+1 (mod 2^D) and load lut_target; a push when full SHALL skip the push, still jump, and set stack_err.
REQ-031 SHALL, on ret_en, pop into prog_ctr; a pop when empty SHALL advance sequentially and set stack_err.
REQ-032 SHALL keep stack_err set until reset.
REQ-033 SHALL, without the macro, have no call_en, ret_en or stack_err ports and no stack storage, with behaviour exactly as REQ-014..REQ-027.

Verification
REQ-034 SHALL verify: reset, start=1, then 5 idle cycles -> prog_ctr 0,1,2,3,4; running=1; done=0.
REQ-035 SHALL verify: at prog_ctr=11, branch_en=1, jump_idx=2, table returns 80 -> lut_addr=2 in the same cycle; prog_ctr=80 next cycle.
REQ-036 SHALL verify: stall=1 with branch_en=1 at prog_ctr=56 -> prog_ctr stays 56; then stall=0 with branch_en=0 -> 57; and prog_ctr=1023 with D=10 -> 0.
REQ-037 SHALL verify: halt_req=1 at prog_ctr=113 -> done=1 and running=0 next cycle, prog_ctr held at 113; start=1 -> prog_ctr=0, RUN.
REQ-038 SHALL verify: rst_n pulled low mid-cycle at prog_ctr=37 -> prog_ctr=0 and state IDLE before the next clk edge.
REQ-039 SHALL verify, with PC_FETCH_RET_STACK_EN: call_en at 20 with target 53 -> 53; ret_en -> 21; five nested calls -> stack_err=1; ret_en on empty -> sequential advance.
